// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges a priority single-cycle ALU result with a FIFO-buffered
// long-latency result onto the registered register-file write port.
module wb_arbiter #(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        alu_valid,
   input  logic [4:0]  alu_reg,
   input  logic [31:0] alu_data,
   output logic        alu_stall,
   input  logic        lng_valid,
   output logic        lng_ready,
   input  logic [4:0]  lng_reg,
   input  logic [31:0] lng_data,
   input  logic [4:0]  q_reg,
   output logic        q_busy,
   output logic        RegWrite,
   output logic [4:0]  WriteReg,
   output logic [31:0] WriteData
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [4:0]  fifo_reg_q  [DEPTH];
   logic [4:0]  fifo_reg_d  [DEPTH];
   logic [31:0] fifo_data_q [DEPTH];
   logic [31:0] fifo_data_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic        regwrite_q, regwrite_d;
   logic [4:0]  writereg_q, writereg_d;
   logic [31:0] writedata_q, writedata_d;

   logic        empty, full, push, pop, win;
   logic [4:0]  win_reg;
   logic [31:0] win_data;
   logic [PW-1:0] offs;

   always_comb begin
      fifo_reg_d  = fifo_reg_q;
      fifo_data_d = fifo_data_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      starve_d    = starve_q;
      win         = 1'b0;
      pop         = 1'b0;
      win_reg     = '0;
      win_data    = '0;

      empty     = (count_q == '0);
      full      = (count_q == (PW+1)'(DEPTH));
      lng_ready = !full;
      alu_stall = !empty && (starve_q == CNT_W'(STARVE_LIMIT));
      push      = lng_valid && !full;

      if (alu_stall || (!alu_valid && !empty)) begin
         win      = 1'b1;
         pop      = 1'b1;
         win_reg  = fifo_reg_q[rd_ptr_q];
         win_data = fifo_data_q[rd_ptr_q];
      end else if (alu_valid) begin
         win      = 1'b1;
         win_reg  = alu_reg;
         win_data = alu_data;
      end

      // ALU beat a waiting FIFO head: count the lost round, saturating at the limit.
      if (pop || empty) begin
         starve_d = '0;
      end else if (alu_valid && (starve_q != CNT_W'(STARVE_LIMIT))) begin
         starve_d = starve_q + 1'b1;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push) begin
         fifo_reg_d[wr_ptr_q]  = lng_reg;
         fifo_data_d[wr_ptr_q] = lng_data;
         wr_ptr_d              = wr_ptr_q + 1'b1;
      end
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);

      regwrite_d  = win && (win_reg != 5'd0);
      writereg_d  = win ? win_reg : writereg_q;
      writedata_d = win ? win_data : writedata_q;
   end

   always_comb begin
      q_busy = 1'b0;
      offs   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs = PW'(i) - rd_ptr_q;
         if (({1'b0, offs} < count_q) && (fifo_reg_q[i] == q_reg)) begin
            q_busy = 1'b1;
         end
      end
      if (regwrite_q && (writereg_q == q_reg)) begin
         q_busy = 1'b1;
      end
      if (q_reg == 5'd0) begin
         q_busy = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_reg_q[i]  <= '0;
            fifo_data_q[i] <= '0;
         end
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         starve_q    <= '0;
         regwrite_q  <= 1'b0;
         writereg_q  <= '0;
         writedata_q <= '0;
      end else begin
         fifo_reg_q  <= fifo_reg_d;
         fifo_data_q <= fifo_data_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         starve_q    <= starve_d;
         regwrite_q  <= regwrite_d;
         writereg_q  <= writereg_d;
         writedata_q <= writedata_d;
      end
   end

   assign RegWrite  = regwrite_q;
   assign WriteReg  = writereg_q;
   assign WriteData = writedata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_wb_arbiter;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        alu_valid = 1'b0;
   logic [4:0]  alu_reg = '0;
   logic [31:0] alu_data = '0;
   logic        lng_valid = 1'b0;
   logic [4:0]  lng_reg = '0;
   logic [31:0] lng_data = '0;
   logic [4:0]  q_reg = '0;
   logic        alu_stall, lng_ready, q_busy, RegWrite;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;

   always #5 clk = ~clk;

   wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_stall(alu_stall),
      .lng_valid(lng_valid), .lng_ready(lng_ready), .lng_reg(lng_reg), .lng_data(lng_data),
      .q_reg(q_reg), .q_busy(q_busy),
      .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
   );

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: queue of {reg, data}, starvation count, and write-port contents.
   logic [36:0] mq[$];
   int          m_starve = 0;
   bit          m_rw = 1'b0;
   logic [4:0]  m_wreg = '0;
   logic [31:0] m_wdata = '0;

   function automatic bit m_busy(input logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      foreach (mq[i]) if (mq[i][36:32] == r) return 1'b1;
      return m_rw && (m_wreg == r);
   endfunction

   always @(posedge clk or negedge reset) begin
      int          sz;
      bit          stall, win, pop;
      logic [36:0] w;
      if (!reset) begin
         mq.delete();
         m_starve = 0;
         m_rw     = 1'b0;
         m_wreg   = '0;
         m_wdata  = '0;
      end else begin
         sz    = mq.size();
         stall = (sz != 0) && (m_starve == LIMIT);
         win   = 1'b0;
         pop   = 1'b0;
         w     = '0;
         if (stall) begin
            w = mq.pop_front(); win = 1'b1; pop = 1'b1;
         end else if (alu_valid) begin
            w = {alu_reg, alu_data}; win = 1'b1;
            if (sz != 0) m_starve = (m_starve >= LIMIT) ? LIMIT : m_starve + 1;
         end else if (sz != 0) begin
            w = mq.pop_front(); win = 1'b1; pop = 1'b1;
         end
         if (pop || sz == 0) m_starve = 0;
         if (lng_valid && sz < DEPTH) mq.push_back({lng_reg, lng_data});
         m_rw = win && (w[36:32] != 5'd0);
         if (win) begin
            m_wreg  = w[36:32];
            m_wdata = w[31:0];
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && reset) begin
         check("m_lng_ready", 32'(lng_ready), 32'(mq.size() < DEPTH));
         check("m_alu_stall", 32'(alu_stall), 32'((mq.size() != 0) && (m_starve == LIMIT)));
         check("m_q_busy", 32'(q_busy), 32'(m_busy(q_reg)));
         check("m_RegWrite", 32'(RegWrite), 32'(m_rw));
         if (m_rw) begin
            check("m_WriteReg", 32'(WriteReg), 32'(m_wreg));
            check("m_WriteData", WriteData, m_wdata);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int pct;

   initial begin
      // Reset state
      #12;
      check("rst_RegWrite", 32'(RegWrite), 32'd0);
      check("rst_WriteReg", 32'(WriteReg), 32'd0);
      check("rst_WriteData", WriteData, 32'd0);
      check("rst_lng_ready", 32'(lng_ready), 32'd1);
      check("rst_alu_stall", 32'(alu_stall), 32'd0);
      check("rst_q_busy", 32'(q_busy), 32'd0);
      @(posedge clk);
      #1;
      reset  = 1'b1;
      chk_en = 1'b1;

      // 1: single ALU write
      alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h1234;
      step();
      alu_valid = 1'b0;
      @(negedge clk);
      check("t1_RegWrite", 32'(RegWrite), 32'd1);
      check("t1_WriteReg", 32'(WriteReg), 32'd5);
      check("t1_WriteData", WriteData, 32'h1234);
      step();
      @(negedge clk);
      check("t1_RegWrite_off", 32'(RegWrite), 32'd0);

      // 2: fill FIFO behind ALU traffic, then drain in order
      step();
      lng_valid = 1'b1; lng_reg = 5'd7; lng_data = 32'hAA;
      alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'h11;
      step();
      lng_reg = 5'd8; lng_data = 32'hBB; alu_reg = 5'd2; alu_data = 32'h22;
      step();
      lng_valid = 1'b0; alu_valid = 1'b0;
      @(negedge clk);
      check("t2_full", 32'(lng_ready), 32'd0);
      check("t2_alu_reg", 32'(WriteReg), 32'd2);
      step();
      @(negedge clk);
      check("t2_first_reg", 32'(WriteReg), 32'd7);
      check("t2_first_data", WriteData, 32'hAA);
      check("t2_ready_back", 32'(lng_ready), 32'd1);
      step();
      @(negedge clk);
      check("t2_second_reg", 32'(WriteReg), 32'd8);
      check("t2_second_data", WriteData, 32'hBB);

      // 3: starvation limit stalls the ALU
      step();
      lng_valid = 1'b1; lng_reg = 5'd9; lng_data = 32'h99;
      step();
      lng_valid = 1'b0;
      alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h33;
      @(negedge clk);
      check("t3_no_stall", 32'(alu_stall), 32'd0);
      repeat (4) step();
      @(negedge clk);
      check("t3_stall", 32'(alu_stall), 32'd1);
      step();
      @(negedge clk);
      check("t3_fifo_reg", 32'(WriteReg), 32'd9);
      check("t3_fifo_we", 32'(RegWrite), 32'd1);
      check("t3_stall_off", 32'(alu_stall), 32'd0);
      step();
      alu_valid = 1'b0;
      @(negedge clk);
      check("t3_alu_reg", 32'(WriteReg), 32'd3);
      check("t3_alu_data", WriteData, 32'h33);

      // 4: register 0 consumed but never written
      step();
      lng_valid = 1'b1; lng_reg = 5'd0; lng_data = 32'hFF;
      alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hEE;
      step();
      lng_valid = 1'b0; alu_valid = 1'b0; q_reg = 5'd0;
      @(negedge clk);
      check("t4_alu_r0", 32'(RegWrite), 32'd0);
      check("t4_qbusy_r0", 32'(q_busy), 32'd0);
      step();
      @(negedge clk);
      check("t4_fifo_r0", 32'(RegWrite), 32'd0);
      step();
      @(negedge clk);
      check("t4_empty_ready", 32'(lng_ready), 32'd1);
      check("t4_idle", 32'(RegWrite), 32'd0);

      // 5: q_busy tracks FIFO and output stage
      step();
      lng_valid = 1'b1; lng_reg = 5'd12; lng_data = 32'hC; q_reg = 5'd12;
      step();
      lng_valid = 1'b0;
      @(negedge clk);
      check("t5_busy_fifo", 32'(q_busy), 32'd1);
      step();
      @(negedge clk);
      check("t5_busy_out", 32'(q_busy), 32'd1);
      check("t5_out_reg", 32'(WriteReg), 32'd12);
      q_reg = 5'd0;
      #1;
      check("t5_busy_r0", 32'(q_busy), 32'd0);

      // 6: asynchronous reset with a full FIFO and a pending write
      step();
      alu_valid = 1'b1; alu_reg = 5'd4; alu_data = 32'h44;
      lng_valid = 1'b1; lng_reg = 5'd13; lng_data = 32'hD;
      step();
      alu_reg = 5'd5; alu_data = 32'h55; lng_reg = 5'd14; lng_data = 32'hE;
      step();
      alu_valid = 1'b0; lng_valid = 1'b0; q_reg = 5'd13;
      @(negedge clk);
      check("t6_full", 32'(lng_ready), 32'd0);
      check("t6_we", 32'(RegWrite), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("t6_rst_we", 32'(RegWrite), 32'd0);
      check("t6_rst_ready", 32'(lng_ready), 32'd1);
      check("t6_rst_busy", 32'(q_busy), 32'd0);
      check("t6_rst_stall", 32'(alu_stall), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("t6_no_write", 32'(RegWrite), 32'd0);
      end

      // Randomized traffic with varying ALU pressure
      pct = 50;
      for (int c = 0; c < 3000; c++) begin
         step();
         if (c % 500 == 0) pct = (pct == 50) ? 92 : 50;
         alu_valid = ($urandom_range(0, 99) < pct);
         alu_reg   = 5'($urandom_range(0, 7));
         alu_data  = $urandom;
         lng_valid = ($urandom_range(0, 99) < 45);
         lng_reg   = 5'($urandom_range(0, 7));
         lng_data  = $urandom;
         q_reg     = 5'($urandom_range(0, 7));
      end
      step();
      alu_valid = 1'b0; lng_valid = 1'b0;
      repeat (6) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
